// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB slave register file with programmable wait states and error response
module apb_slave_regfile #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 16,
  parameter int WAIT_STATES    = 0
) (
  input  logic                      apbClk,
  input  logic                      rst,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic                      PREADY,
  output logic [APB_DATA_WIDTH-1:0] PRDATA,
  output logic                      PSLVERR
);

  localparam int         IDX_W = $clog2(NUM_REGS);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [3:0]                r_cnt;
  logic [3:0]                w_cnt_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_write;
  logic                      r_err;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic [APB_DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                      r_pready;
  logic [APB_DATA_WIDTH-1:0] r_prdata;
  logic                      r_pslverr;
  logic                      w_pready_nxt;
  logic [APB_DATA_WIDTH-1:0] w_prdata_nxt;
  logic                      w_pslverr_nxt;

  logic                      w_setup;
  logic                      w_latch;
  logic                      w_commit;
  logic [IDX_W-1:0]          w_in_idx;
  logic                      w_in_range;
  logic [IDX_W-1:0]          w_rd_idx;
  logic                      w_rd_write;
  logic                      w_rd_err;
  logic [APB_DATA_WIDTH-1:0] w_rd_data;

  assign w_setup    = PSEL & ~PENABLE;
  assign w_in_idx   = PADDR[2 +: IDX_W];
  assign w_in_range = (PADDR[1:0] == 2'b00) &&
                      (PADDR[APB_ADDR_WIDTH-1:IDX_W+2] == '0);

  // With zero wait states READY is entered on the setup edge itself, so the
  // read data must come from the live bus rather than the latched copy.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_rd_idx   = w_in_idx;
      w_rd_write = PWRITE;
      w_rd_err   = ~w_in_range;
    end else begin
      w_rd_idx   = r_idx;
      w_rd_write = r_write;
      w_rd_err   = r_err;
    end
    w_rd_data = (!w_rd_write && !w_rd_err) ? r_regs[w_rd_idx] : '0;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pready_nxt  = r_pready;
    w_prdata_nxt  = r_prdata;
    w_pslverr_nxt = r_pslverr;
    w_latch       = 1'b0;
    w_commit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_latch   = 1'b1;
          w_cnt_nxt = WS;
          if (WS == 4'd0) begin
            w_state_nxt   = S_READY;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = w_rd_err;
            w_prdata_nxt  = w_rd_data;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = 4'd0;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
          w_prdata_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_nxt   = S_READY;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = w_rd_err;
            w_prdata_nxt  = w_rd_data;
          end
        end
      end
      S_READY: begin
        if (!PSEL || PENABLE) begin
          // Deselect aborts without a commit; completion commits good writes.
          w_commit      = PSEL & r_write & ~r_err;
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = 4'd0;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
          w_prdata_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = 4'd0;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_prdata_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge apbClk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pready  <= w_pready_nxt;
      r_prdata  <= w_prdata_nxt;
      r_pslverr <= w_pslverr_nxt;
    end
  end

  always_ff @(posedge apbClk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_idx   <= w_in_idx;
      r_write <= PWRITE;
      r_err   <= ~w_in_range;
      r_wdata <= PWDATA;
    end
  end

  always_ff @(posedge apbClk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[r_idx] <= r_wdata;
    end
  end

  assign PREADY  = r_pready;
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed bench for apb_slave_regfile at 0, 3 and 2 wait states
module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic        pready  [3];
  logic [31:0] prdata  [3];
  logic        pslverr [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: no wait states, 1: three wait states, 2: two wait states.
  apb_slave_regfile #(.WAIT_STATES(0)) u_ws0 (
    .apbClk(clk), .rst(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));
  apb_slave_regfile #(.WAIT_STATES(3)) u_ws3 (
    .apbClk(clk), .rst(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));
  apb_slave_regfile #(.WAIT_STATES(2)) u_ws2 (
    .apbClk(clk), .rst(rst), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n counts access-phase cycles, including the completing one.
  task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int n);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = wd;
    @(posedge clk); #1;
    penable[k] = 1'b1;
    n = 1;
    while (pready[k] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("pready_seen", 64'(pready[k]), 64'd1);
    rd  = prdata[k];
    err = pslverr[k];
    @(posedge clk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          n;
  int          t0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_pready", 64'(pready[k]), 64'd0);
      check("rst_prdata", 64'(prdata[k]), 64'd0);
      check("rst_pslverr", 64'(pslverr[k]), 64'd0);
    end

    // 1: zero wait states, two-cycle transfers
    xfer(0, 1, 32'h8, 32'hDEAD_BEEF, rd, err, n);
    check("t1_wr_cycles", 64'(n), 64'd1);
    check("t1_wr_err", 64'(err), 64'd0);
    check("t1_wr_prdata", 64'(rd), 64'd0);
    check("t1_after_pready", 64'(pready[0]), 64'd0);
    xfer(0, 0, 32'h8, 32'h0, rd, err, n);
    check("t1_rd_data", 64'(rd), 64'hDEAD_BEEF);
    check("t1_rd_err", 64'(err), 64'd0);
    check("t1_rd_cycles", 64'(n), 64'd1);

    // 2: three wait states
    xfer(1, 1, 32'h4, 32'h1234_5678, rd, err, n);
    check("t2_wr_cycles", 64'(n), 64'd4);
    xfer(1, 0, 32'h4, 32'h0, rd, err, n);
    check("t2_rd_cycles", 64'(n), 64'd4);
    check("t2_rd_data", 64'(rd), 64'h1234_5678);
    check("t2_rd_err", 64'(err), 64'd0);

    // 3: out-of-range and unaligned accesses
    xfer(0, 1, 32'h40, 32'hAAAA_AAAA, rd, err, n);
    check("t3_oor_wr_err", 64'(err), 64'd1);
    xfer(0, 1, 32'h6, 32'h5555_5555, rd, err, n);
    check("t3_unal_wr_err", 64'(err), 64'd1);
    xfer(0, 0, 32'h0, 32'h0, rd, err, n);
    check("t3_reg0_kept", 64'(rd), 64'd0);
    xfer(0, 0, 32'h4, 32'h0, rd, err, n);
    check("t3_reg1_kept", 64'(rd), 64'd0);
    xfer(0, 0, 32'h8, 32'h0, rd, err, n);
    check("t3_reg2_kept", 64'(rd), 64'hDEAD_BEEF);
    xfer(0, 0, 32'h40, 32'h0, rd, err, n);
    check("t3_oor_rd_data", 64'(rd), 64'd0);
    check("t3_oor_rd_err", 64'(err), 64'd1);

    // 4: back-to-back writes then reads, no idle cycles
    t0 = cyc;
    for (int i = 0; i < 16; i++) xfer(0, 1, 32'(i * 4), 32'(i * 32'h11), rd, err, n);
    check("t4_wr_cycles", 64'(cyc - t0), 64'd32);
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      xfer(0, 0, 32'(i * 4), 32'h0, rd, err, n);
      check($sformatf("t4_rd_%0d", i), 64'(rd), 64'(i * 32'h11));
    end
    check("t4_rd_cycles", 64'(cyc - t0), 64'd32);

    // 5: deselect during wait states aborts the write
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'hC; pwdata[2] = 32'h0000_CAFE;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    check("t5_wait_pready", 64'(pready[2]), 64'd0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(posedge clk); #1;
    check("t5_abort_pready", 64'(pready[2]), 64'd0);
    xfer(2, 0, 32'hC, 32'h0, rd, err, n);
    check("t5_reg_unchanged", 64'(rd), 64'd0);
    check("t5_rd_cycles", 64'(n), 64'd3);
    xfer(2, 1, 32'hC, 32'h0000_0077, rd, err, n);
    xfer(2, 0, 32'hC, 32'h0, rd, err, n);
    check("t5_next_ok", 64'(rd), 64'h77);
    check("t5_next_err", 64'(err), 64'd0);

    // 6: reset during the access phase
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h10; pwdata[0] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    check("t6_pready_before", 64'(pready[0]), 64'd1);
    #2 rst = 1'b1;
    #1 check("t6_pready_async", 64'(pready[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
    xfer(0, 0, 32'h10, 32'h0, rd, err, n);
    check("t6_reg_zero", 64'(rd), 64'd0);
    xfer(0, 0, 32'h8, 32'h0, rd, err, n);
    check("t6_reg_cleared", 64'(rd), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
